// File: rtl/mem_load_unit_if.sv
// Load-unit bus bundle: MEM-stage request, store-commit snoop, memory read port and result.
interface mem_load_unit_if;
  logic        in_LD;
  logic [1:0]  in_LDT;
  logic        in_SGN;
  logic [31:0] in_ADDR;
  logic        in_SVLD;
  logic [31:0] in_SADDR;
  logic [31:0] in_SDATA;
  logic        out_MREQ;
  logic [31:0] out_MADDR;
  logic        in_MACK;
  logic [31:0] in_MDATA;
  logic        out_STALL;
  logic [31:0] out_RDATA;
  logic        out_RVLD;
  logic        out_ERR;
  logic        out_ECODE;

  modport slave (
    input  in_LD, in_LDT, in_SGN, in_ADDR, in_SVLD, in_SADDR, in_SDATA, in_MACK, in_MDATA,
    output out_MREQ, out_MADDR, out_STALL, out_RDATA, out_RVLD, out_ERR, out_ECODE
  );

  modport master (
    output in_LD, in_LDT, in_SGN, in_ADDR, in_SVLD, in_SADDR, in_SDATA, in_MACK, in_MDATA,
    input  out_MREQ, out_MADDR, out_STALL, out_RDATA, out_RVLD, out_ERR, out_ECODE
  );
endinterface

// File: rtl/mem_load_unit.sv
// Load unit: alignment check, one-entry store-buffer forwarding, memory read with
// wait timeout, and little-endian byte/half extraction with sign/zero extension.
module mem_load_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input logic            in_CLK,
  input logic            in_RST,
  mem_load_unit_if.slave bus
);
  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr;
  logic [1:0]  r_ldt;
  logic        r_sgn;
  logic        r_sb_vld;
  logic [29:0] r_sb_addr;
  logic [31:0] r_sb_data;
  logic        r_mreq;
  logic [31:0] r_maddr;
  logic [31:0] r_rdata;
  logic        r_rvld;
  logic        r_err;
  logic        r_ecode;

  logic [31:0] w_lk_addr;
  logic        w_hit;
  logic [31:0] w_hit_data;
  logic        w_misal;
  logic        w_unused;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] ldt,
                                          input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (ldt)
      2'b01:   res = {{16{sgn & h[15]}}, h};
      2'b10:   res = {{24{sgn & b[7]}}, b};
      default: res = w;
    endcase
    return res;
  endfunction

  // Lookup uses the live address in IDLE and the latched one in WAIT; a store
  // committing in the same cycle beats the buffered entry.
  assign w_lk_addr = (r_state == IDLE) ? bus.in_ADDR : r_addr;

  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = r_sb_data;
    if (bus.in_SVLD && (bus.in_SADDR[31:2] == w_lk_addr[31:2])) begin
      w_hit      = 1'b1;
      w_hit_data = bus.in_SDATA;
    end else if (r_sb_vld && (r_sb_addr == w_lk_addr[31:2])) begin
      w_hit      = 1'b1;
    end
  end

  always_comb begin
    case (bus.in_LDT)
      2'b01:   w_misal = bus.in_ADDR[0];
      2'b10:   w_misal = 1'b0;
      default: w_misal = |bus.in_ADDR[1:0];
    endcase
  end

  assign w_unused = ^bus.in_SADDR[1:0];

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_ldt     <= '0;
      r_sgn     <= 1'b0;
      r_sb_vld  <= 1'b0;
      r_sb_addr <= '0;
      r_sb_data <= '0;
      r_mreq    <= 1'b0;
      r_maddr   <= '0;
      r_rdata   <= '0;
      r_rvld    <= 1'b0;
      r_err     <= 1'b0;
      r_ecode   <= 1'b0;
    end else begin
      r_rvld  <= 1'b0;
      r_err   <= 1'b0;
      r_ecode <= 1'b0;
      r_rdata <= '0;
      if (bus.in_SVLD) begin
        r_sb_vld  <= 1'b1;
        r_sb_addr <= bus.in_SADDR[31:2];
        r_sb_data <= bus.in_SDATA;
      end
      unique case (r_state)
        IDLE: begin
          if (bus.in_LD) begin
            r_addr <= bus.in_ADDR;
            r_ldt  <= bus.in_LDT;
            r_sgn  <= bus.in_SGN;
            if (w_misal) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else if (w_hit) begin
              r_state <= DONE;
              r_rvld  <= 1'b1;
              r_rdata <= extract(w_hit_data, bus.in_LDT, bus.in_SGN, bus.in_ADDR[1:0]);
            end else begin
              r_state <= WAIT;
              r_cnt   <= '0;
              r_mreq  <= 1'b1;
              r_maddr <= {bus.in_ADDR[31:2], 2'b00};
            end
          end
        end
        WAIT: begin
          if (bus.in_MACK) begin
            r_state <= DONE;
            r_mreq  <= 1'b0;
            r_maddr <= '0;
            r_rvld  <= 1'b1;
            r_rdata <= extract(w_hit ? w_hit_data : bus.in_MDATA, r_ldt, r_sgn, r_addr[1:0]);
          end else if (r_cnt == CW'(MAX_WAIT - 1)) begin
            r_state <= ERR;
            r_mreq  <= 1'b0;
            r_maddr <= '0;
            r_err   <= 1'b1;
            r_ecode <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_STALL = !in_RST && (((r_state == IDLE) && bus.in_LD) || (r_state == WAIT));
  assign bus.out_MREQ  = r_mreq;
  assign bus.out_MADDR = r_maddr;
  assign bus.out_RDATA = r_rdata;
  assign bus.out_RVLD  = r_rvld;
  assign bus.out_ERR   = r_err;
  assign bus.out_ECODE = r_ecode;
endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: miss, extraction, forwarding, errors, timeout, reset.
module tb_mem_load_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_load_unit_if ifc ();

  mem_load_unit #(.MAX_WAIT(16)) dut (
    .in_CLK (clk),
    .in_RST (rst),
    .bus    (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one load and runs it to RVLD/ERR (bounded); ack_at is the 1-based WAIT cycle to ack, 0 for never.
  task automatic run_load(input logic [1:0] ldt, input logic sgn, input logic [31:0] addr,
                          input int ack_at, input logic [31:0] mdata,
                          output int n_mreq, output int n_stall, output logic [31:0] maddr,
                          output logic rvld, output logic err, output logic ecode,
                          output logic [31:0] rdata, output logic mreq_end);
    n_mreq = 0; n_stall = 0; maddr = '0; rvld = 0; err = 0; ecode = 0; rdata = '0; mreq_end = 0;
    ifc.in_LD = 1'b1; ifc.in_LDT = ldt; ifc.in_SGN = sgn; ifc.in_ADDR = addr;
    for (int c = 0; c < 40; c++) begin
      if (ifc.out_MREQ) begin
        n_mreq++;
        maddr = ifc.out_MADDR;
        ifc.in_MACK  = (n_mreq == ack_at);
        ifc.in_MDATA = mdata;
      end else begin
        ifc.in_MACK = 1'b0;
      end
      #1;
      if (ifc.out_STALL) n_stall++;
      @(posedge clk);
      #1;
      if (ifc.out_RVLD || ifc.out_ERR) begin
        rvld = ifc.out_RVLD; err = ifc.out_ERR; ecode = ifc.out_ECODE;
        rdata = ifc.out_RDATA; mreq_end = ifc.out_MREQ;
        break;
      end
    end
    ifc.in_LD = 1'b0; ifc.in_MACK = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ifc.in_LD = 1'b1; ifc.in_MACK = 1'b1;
    tick();
    tick();
    total++; if (ifc.out_MREQ !== 1'b0) begin bad++; $display("FAIL reset_mreq got=%b exp=0", ifc.out_MREQ); end
    total++; if (ifc.out_RVLD !== 1'b0) begin bad++; $display("FAIL reset_rvld got=%b exp=0", ifc.out_RVLD); end
    total++; if (ifc.out_ERR !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", ifc.out_ERR); end
    total++; if (ifc.out_RDATA !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", ifc.out_RDATA); end
    total++; if (ifc.out_STALL !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", ifc.out_STALL); end
    rst = 1'b0; ifc.in_LD = 1'b0; ifc.in_MACK = 1'b0;
    tick();
  endtask

  task automatic test_miss();
    int n_mreq, n_stall; logic [31:0] maddr, rdata; logic rvld, err, ecode, mreq_end;
    run_load(2'b00, 1'b0, 32'h100, 1, 32'hDEADBEEF, n_mreq, n_stall, maddr, rvld, err, ecode, rdata, mreq_end);
    total++; if (n_mreq !== 1) begin bad++; $display("FAIL miss_mreq_cycles got=%0d exp=1", n_mreq); end
    total++; if (maddr !== 32'h100) begin bad++; $display("FAIL miss_maddr got=%h exp=00000100", maddr); end
    total++; if (rvld !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL miss_rvld got=%b/%b exp=1/0", rvld, err); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL miss_rdata got=%h exp=deadbeef", rdata); end
    total++; if (n_stall !== 2) begin bad++; $display("FAIL miss_stall got=%0d exp=2", n_stall); end
    total++; if (mreq_end !== 1'b0) begin bad++; $display("FAIL miss_mreq_done got=%b exp=0", mreq_end); end
    total++; if (ifc.out_RVLD !== 1'b0) begin bad++; $display("FAIL miss_rvld_once got=%b exp=0", ifc.out_RVLD); end
  endtask

  task automatic test_byte();
    int n_mreq, n_stall; logic [31:0] maddr, rdata; logic rvld, err, ecode, mreq_end;
    run_load(2'b10, 1'b1, 32'h103, 1, 32'h80FF0000, n_mreq, n_stall, maddr, rvld, err, ecode, rdata, mreq_end);
    total++; if (maddr !== 32'h100) begin bad++; $display("FAIL byte_maddr got=%h exp=00000100", maddr); end
    total++; if (rvld !== 1'b1 || rdata !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_sext got=%b/%h exp=1/ffffff80", rvld, rdata); end
    run_load(2'b10, 1'b0, 32'h103, 1, 32'h80FF0000, n_mreq, n_stall, maddr, rvld, err, ecode, rdata, mreq_end);
    total++; if (rvld !== 1'b1 || rdata !== 32'h00000080) begin bad++; $display("FAIL byte_zext got=%b/%h exp=1/00000080", rvld, rdata); end
  endtask

  task automatic test_forward();
    int n_mreq, n_stall; logic [31:0] maddr, rdata; logic rvld, err, ecode, mreq_end;
    ifc.in_SVLD = 1'b1; ifc.in_SADDR = 32'h200; ifc.in_SDATA = 32'h12345678;
    tick();
    ifc.in_SVLD = 1'b0;
    run_load(2'b01, 1'b0, 32'h202, 0, 32'h0, n_mreq, n_stall, maddr, rvld, err, ecode, rdata, mreq_end);
    total++; if (n_mreq !== 0) begin bad++; $display("FAIL fwd_no_mreq got=%0d exp=0", n_mreq); end
    total++; if (n_stall !== 1) begin bad++; $display("FAIL fwd_stall got=%0d exp=1", n_stall); end
    total++; if (rvld !== 1'b1 || rdata !== 32'h00001234) begin bad++; $display("FAIL fwd_rdata got=%b/%h exp=1/00001234", rvld, rdata); end
  endtask

  task automatic test_fwd_same_cycle();
    ifc.in_SVLD = 1'b1; ifc.in_SADDR = 32'h500; ifc.in_SDATA = 32'hA5A58001;
    ifc.in_LD = 1'b1; ifc.in_LDT = 2'b10; ifc.in_SGN = 1'b1; ifc.in_ADDR = 32'h501;
    #1;
    total++; if (ifc.out_STALL !== 1'b1) begin bad++; $display("FAIL same_stall got=%b exp=1", ifc.out_STALL); end
    tick();
    ifc.in_SVLD = 1'b0;
    total++; if (ifc.out_RVLD !== 1'b1 || ifc.out_RDATA !== 32'hFFFFFF80 || ifc.out_MREQ !== 1'b0)
      begin bad++; $display("FAIL same_fwd got=%b/%h/%b exp=1/ffffff80/0", ifc.out_RVLD, ifc.out_RDATA, ifc.out_MREQ); end
    ifc.in_LD = 1'b0;
    tick();
  endtask

  task automatic test_wait_override();
    ifc.in_LD = 1'b1; ifc.in_LDT = 2'b00; ifc.in_SGN = 1'b0; ifc.in_ADDR = 32'h600;
    tick();
    total++; if (ifc.out_MREQ !== 1'b1) begin bad++; $display("FAIL ovr_mreq got=%b exp=1", ifc.out_MREQ); end
    ifc.in_MACK = 1'b1; ifc.in_MDATA = 32'h11111111;
    ifc.in_SVLD = 1'b1; ifc.in_SADDR = 32'h600; ifc.in_SDATA = 32'h22222222;
    tick();
    ifc.in_MACK = 1'b0; ifc.in_SVLD = 1'b0;
    total++; if (ifc.out_RVLD !== 1'b1 || ifc.out_RDATA !== 32'h22222222)
      begin bad++; $display("FAIL ovr_rdata got=%b/%h exp=1/22222222", ifc.out_RVLD, ifc.out_RDATA); end
    ifc.in_LD = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    int n_mreq, n_stall; logic [31:0] maddr, rdata; logic rvld, err, ecode, mreq_end;
    run_load(2'b00, 1'b0, 32'h101, 1, 32'hFFFFFFFF, n_mreq, n_stall, maddr, rvld, err, ecode, rdata, mreq_end);
    total++; if (err !== 1'b1 || ecode !== 1'b0 || rvld !== 1'b0)
      begin bad++; $display("FAIL mis_word got=%b/%b/%b exp=1/0/0", err, ecode, rvld); end
    total++; if (n_mreq !== 0 || rdata !== 32'h0) begin bad++; $display("FAIL mis_word_mreq got=%0d/%h exp=0/0", n_mreq, rdata); end
    run_load(2'b01, 1'b1, 32'h103, 1, 32'hFFFFFFFF, n_mreq, n_stall, maddr, rvld, err, ecode, rdata, mreq_end);
    total++; if (err !== 1'b1 || ecode !== 1'b0 || n_mreq !== 0)
      begin bad++; $display("FAIL mis_half got=%b/%b/%0d exp=1/0/0", err, ecode, n_mreq); end
  endtask

  task automatic test_timeout();
    int n_mreq, n_stall; logic [31:0] maddr, rdata; logic rvld, err, ecode, mreq_end;
    run_load(2'b00, 1'b0, 32'h700, 0, 32'h0, n_mreq, n_stall, maddr, rvld, err, ecode, rdata, mreq_end);
    total++; if (n_mreq !== 16) begin bad++; $display("FAIL tmo_mreq_cycles got=%0d exp=16", n_mreq); end
    total++; if (err !== 1'b1 || ecode !== 1'b1 || rvld !== 1'b0)
      begin bad++; $display("FAIL tmo_err got=%b/%b/%b exp=1/1/0", err, ecode, rvld); end
    total++; if (n_stall !== 17 || mreq_end !== 1'b0) begin bad++; $display("FAIL tmo_stall got=%0d/%b exp=17/0", n_stall, mreq_end); end
    run_load(2'b00, 1'b0, 32'h700, 16, 32'h0BADF00D, n_mreq, n_stall, maddr, rvld, err, ecode, rdata, mreq_end);
    total++; if (rvld !== 1'b1 || err !== 1'b0 || rdata !== 32'h0BADF00D)
      begin bad++; $display("FAIL tmo_last_ack got=%b/%b/%h exp=1/0/0badf00d", rvld, err, rdata); end
    total++; if (n_mreq !== 16) begin bad++; $display("FAIL tmo_last_ack_cycles got=%0d exp=16", n_mreq); end
  endtask

  task automatic test_reset_mid_wait();
    int n_mreq, n_stall; logic [31:0] maddr, rdata; logic rvld, err, ecode, mreq_end;
    ifc.in_SVLD = 1'b1; ifc.in_SADDR = 32'h800; ifc.in_SDATA = 32'h55AA55AA;
    tick();
    ifc.in_SVLD = 1'b0;
    ifc.in_LD = 1'b1; ifc.in_LDT = 2'b00; ifc.in_SGN = 1'b0; ifc.in_ADDR = 32'h900;
    tick(); tick(); tick();
    total++; if (ifc.out_MREQ !== 1'b1) begin bad++; $display("FAIL rmw_mreq_before got=%b exp=1", ifc.out_MREQ); end
    rst = 1'b1;
    tick();
    rst = 1'b0; ifc.in_LD = 1'b0; ifc.in_MACK = 1'b1; ifc.in_MDATA = 32'hFEEDFACE;
    #1;
    total++; if (ifc.out_MREQ !== 1'b0 || ifc.out_STALL !== 1'b0)
      begin bad++; $display("FAIL rmw_idle got=%b/%b exp=0/0", ifc.out_MREQ, ifc.out_STALL); end
    tick();
    ifc.in_MACK = 1'b0;
    total++; if (ifc.out_RVLD !== 1'b0 || ifc.out_ERR !== 1'b0 || ifc.out_MREQ !== 1'b0)
      begin bad++; $display("FAIL rmw_late_ack got=%b/%b/%b exp=0/0/0", ifc.out_RVLD, ifc.out_ERR, ifc.out_MREQ); end
    run_load(2'b00, 1'b0, 32'h800, 1, 32'h13572468, n_mreq, n_stall, maddr, rvld, err, ecode, rdata, mreq_end);
    total++; if (n_mreq !== 1 || rdata !== 32'h13572468)
      begin bad++; $display("FAIL rmw_buf_invalid got=%0d/%h exp=1/13572468", n_mreq, rdata); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    ifc.in_LD = 1'b0; ifc.in_LDT = 2'b00; ifc.in_SGN = 1'b0; ifc.in_ADDR = '0;
    ifc.in_SVLD = 1'b0; ifc.in_SADDR = '0; ifc.in_SDATA = '0;
    ifc.in_MACK = 1'b0; ifc.in_MDATA = '0;
    test_reset();
    test_miss();
    test_byte();
    test_forward();
    test_fwd_same_cycle();
    test_wait_override();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
